// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch stage with one outstanding imem read and a 2-entry {pc, instr} buffer.
// Ports: i_clk/i_rst_n (sync active-low reset); i_pc, i_flush from the PC stage; o_pc_en advance strobe;
// o_imem_req/o_imem_addr/i_imem_ack/i_imem_rdata memory read port; o_id_valid/i_id_ready/o_id_pc/o_id_instr to decode.
// Optional macro FETCH_STALL_CNT_EN adds o_stall_cnt, a wrapping count of empty cycles outside DROP.
module fetch_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  output logic        o_pc_en,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_id_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_instr
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] o_stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;
  state_e      state_q, state_d;
  logic        req_q, req_d, pc_en_q, pc_en_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  count_q, count_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [31:0] ent_pc_q [2], ent_pc_d [2];
  logic [31:0] ent_instr_q [2], ent_instr_d [2];
  logic        push, pop, issue;
  assign pop   = (count_q != 2'd0) & i_id_ready;
  assign push  = (state_q == WAIT) & i_imem_ack & ~i_flush;
  // Issue is gated on the registered count, so a pop in the same cycle does not free a slot early.
  assign issue = (state_q == IDLE) & (count_q < 2'(DEPTH)) & ~i_flush;
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    pc_en_d     = issue;
    ent_pc_d    = ent_pc_q;
    ent_instr_d = ent_instr_q;
    if (issue) begin
      state_d = WAIT;
      req_d   = 1'b1;
      addr_d  = i_pc;
    end else if (state_q == WAIT && i_imem_ack) begin
      state_d = IDLE;
      req_d   = 1'b0;
    end else if (state_q == WAIT && i_flush) begin
      state_d = DROP;
      req_d   = 1'b0;
    end else if (state_q == DROP && i_imem_ack) begin
      state_d = IDLE;
    end
    if (push) begin
      ent_pc_d[wr_q]    = addr_q;
      ent_instr_d[wr_q] = i_imem_rdata;
    end
    // A flush kills everything buffered, including an entry popped in the same cycle.
    count_d = i_flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    rd_d    = ~i_flush & (rd_q ^ pop);
    wr_d    = ~i_flush & (wr_q ^ push);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= 32'h0;
      pc_en_q <= 1'b0;
      count_q <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pc_en_q <= pc_en_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end
  // Entry storage needs no reset: it is only visible while count_q covers it.
  always_ff @(posedge i_clk) begin
    ent_pc_q    <= ent_pc_d;
    ent_instr_q <= ent_instr_d;
  end
  assign o_pc_en     = pc_en_q;
  assign o_imem_req  = req_q;
  assign o_imem_addr = addr_q;
  assign o_id_valid  = count_q != 2'd0;
  assign o_id_pc     = o_id_valid ? ent_pc_q[rd_q] : 32'h0;
  assign o_id_instr  = o_id_valid ? ent_instr_q[rd_q] : NOP_INSTR;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  assign stall_cnt_d = stall_cnt_q + {31'b0, (count_q == 2'd0) & (state_q != DROP)};
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) stall_cnt_q <= 32'h0;
    else stall_cnt_q <= stall_cnt_d;
  end
  assign o_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: randomized and directed checks of fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;
  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_imem_ack, i_id_ready;
  logic [31:0] i_pc, i_imem_rdata;
  logic        o_pc_en, o_imem_req, o_id_valid;
  logic [31:0] o_imem_addr, o_id_pc, o_id_instr;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] o_stall_cnt;
`endif
  logic [98:0] obs;
  int checks = 0;
  int errors = 0;
  logic [63:0] q [$];
  logic        m_busy, m_drop, m_req, m_pc_en;
  logic [31:0] m_addr, m_stall, flush_target, fixed_word;
  int          wait_cnt, mem_lat;
  bit          auto_mem, rand_lat, fixed_en;

  fetch_buffer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc(i_pc), .i_flush(i_flush),
    .o_pc_en(o_pc_en), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
    .o_id_valid(o_id_valid), .i_id_ready(i_id_ready), .o_id_pc(o_id_pc), .o_id_instr(o_id_instr)
`ifdef FETCH_STALL_CNT_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;
  assign obs = {o_imem_req, o_imem_addr, o_pc_en, o_id_valid, o_id_pc, o_id_instr};

  function automatic logic [98:0] exp_vec();
    logic [63:0] h;
    logic v;
    v = q.size() != 0;
    h = v ? q[0] : {32'h0, 32'h0000_0013};
    return {m_req, m_addr, m_pc_en, v, h};
  endfunction

  // Reference: a fetch is either absent, pending, or pending-but-doomed; delivered words go into a FIFO queue.
  task automatic model_step();
    bit pop, push, issued;
    int sz;
    if (!i_rst_n) begin
      q.delete();
      {m_busy, m_drop, m_req, m_pc_en} = '0;
      m_addr  = 32'h0;
      m_stall = 32'h0;
      return;
    end
    sz = q.size();
    if (sz == 0 && !m_drop) m_stall++;
    pop = sz != 0 && i_id_ready;
    push = 0;
    issued = 0;
    if (!m_busy) begin
      if (sz < 2 && !i_flush) begin
        m_busy = 1; m_req = 1; m_addr = i_pc; issued = 1;
      end
    end else if (i_imem_ack) begin
      push = !m_drop && !i_flush;
      m_busy = 0; m_drop = 0; m_req = 0;
    end else if (i_flush && !m_drop) begin
      m_drop = 1; m_req = 0;
    end
    m_pc_en = issued;
    if (pop) void'(q.pop_front());
    if (push) q.push_back({m_addr, i_imem_rdata});
    if (i_flush) q.delete();
    if (issued) wait_cnt = rand_lat ? $urandom_range(1, 4) : mem_lat;
    else if (m_busy && wait_cnt > 0) wait_cnt--;
  endtask

  task automatic cycle();
    logic fl, pe;
    @(posedge i_clk);
    fl = i_flush;
    pe = m_pc_en;
    model_step();
    #1;
    if (fl) i_pc = flush_target;
    else if (pe) i_pc = i_pc + 32'd4;
    if (auto_mem) begin
      i_imem_ack = m_busy && wait_cnt == 0;
      i_imem_rdata = i_imem_ack ? (fixed_en ? fixed_word : {m_addr[15:0], 16'h0093}) : $urandom;
    end
  endtask

  task automatic do_reset();
    i_rst_n = 0; i_flush = 0; i_imem_ack = 0; i_id_ready = 1;
    auto_mem = 1; rand_lat = 0; fixed_en = 0; mem_lat = 1;
    cycle();
    cycle();
    i_pc = 32'h0;
    i_rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== {1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0013}) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", obs, {1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0013});
    end
`ifdef FETCH_STALL_CNT_EN
    checks++;
    if (o_stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_stall: got %h expected 0", o_stall_cnt); end
`endif
  endtask

  task automatic test_basic_fetch();
    bit found;
    do_reset();
    fixed_en = 1; fixed_word = 32'h0050_0093;
    cycle();
    checks++;
    if ({o_pc_en, o_imem_req, o_imem_addr} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL basic_issue: got en/req/addr %b/%b/%h expected 1/1/0", o_pc_en, o_imem_req, o_imem_addr);
    end
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL basic_cycle: got %h expected %h", obs, exp_vec()); end
      if (o_id_valid) begin
        found = 1;
        checks++;
        if ({o_id_pc, o_id_instr} !== {32'h0, 32'h0050_0093}) begin
          errors++; $display("FAIL basic_head: got %h/%h expected 0/00500093", o_id_pc, o_id_instr);
        end
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL basic_valid_timeout: got no valid expected valid"); end
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      cycle();
      if (o_imem_req && o_imem_addr == 32'h4) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL basic_next_addr: got addr %h expected request at 4", o_imem_addr); end
  endtask

  task automatic test_backpressure();
    bit found;
    do_reset();
    i_id_ready = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL bp_fill: got %h expected %h", obs, exp_vec()); end
    end
    checks++;
    if ({o_imem_req, o_pc_en, o_id_valid, o_id_pc} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL bp_full: got req/en/valid/pc %b/%b/%b/%h expected 0/0/1/0", o_imem_req, o_pc_en, o_id_valid, o_id_pc);
    end
    i_id_ready = 1;
    cycle();
    checks++;
    if ({o_id_valid, o_id_pc} !== {1'b1, 32'h4}) begin
      errors++; $display("FAIL bp_second_head: got %b/%h expected 1/4", o_id_valid, o_id_pc);
    end
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL bp_drain: got %h expected %h", obs, exp_vec()); end
      if (o_imem_req && o_imem_addr == 32'h8) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL bp_resume: got addr %h expected request at 8", o_imem_addr); end
  endtask

  task automatic test_flush_drop();
    bit found;
    do_reset();
    mem_lat = 4; fixed_en = 1; fixed_word = 32'hDEAD_BEEF;
    cycle();
    i_flush = 1; flush_target = 32'h400;
    cycle();
    i_flush = 0;
    checks++;
    if ({o_imem_req, o_id_valid} !== 2'b00) begin
      errors++; $display("FAIL drop_req: got req/valid %b/%b expected 0/0", o_imem_req, o_id_valid);
    end
    found = 0;
    for (int i = 0; i < 15 && !found; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL drop_cycle: got %h expected %h", obs, exp_vec()); end
      checks++;
      if (o_id_instr === 32'hDEAD_BEEF) begin errors++; $display("FAIL drop_leak: got instr %h expected not deadbeef", o_id_instr); end
      if (o_imem_req && o_imem_addr == 32'h400) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL drop_redirect: got addr %h expected request at 400", o_imem_addr); end
  endtask

  task automatic test_flush_ack();
    bit found;
    do_reset();
    i_id_ready = 0;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL fa_setup: got %h expected %h", obs, exp_vec()); end
      if (i_imem_ack && o_id_valid) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL fa_timeout: got no ack with one entry expected one"); end
    i_flush = 1; flush_target = 32'h800;
    cycle();
    i_flush = 0;
    checks++;
    if ({o_id_valid, o_id_instr, o_imem_req} !== {1'b0, 32'h0000_0013, 1'b0}) begin
      errors++; $display("FAIL fa_kill: got valid/instr/req %b/%h/%b expected 0/00000013/0", o_id_valid, o_id_instr, o_imem_req);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    mem_lat = 3;
    cycle();
    cycle();
    i_rst_n = 0;
    cycle();
    checks++;
    if (obs !== {1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0013}) begin
      errors++; $display("FAIL rw_reset: got %h expected reset values", obs);
    end
    auto_mem = 0; i_rst_n = 1; i_flush = 1; flush_target = 32'h40; i_imem_ack = 1; i_imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if ({o_id_valid, o_imem_req} !== 2'b00) begin
        errors++; $display("FAIL rw_stray_ack: got valid/req %b/%b expected 0/0", o_id_valid, o_imem_req);
      end
    end
    i_imem_ack = 0; i_flush = 0; auto_mem = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL rw_recover: got %h expected %h", obs, exp_vec()); end
    end
  endtask

  task automatic test_random();
    do_reset();
    rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      i_id_ready = $urandom_range(0, 3) != 0;
      i_flush = $urandom_range(0, 15) == 0;
      flush_target = $urandom & 32'h0000_FFFC;
      cycle();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random_cycle %0d: got %h expected %h", i, obs, exp_vec()); end
`ifdef FETCH_STALL_CNT_EN
      checks++;
      if (o_stall_cnt !== m_stall) begin errors++; $display("FAIL random_stall: got %h expected %h", o_stall_cnt, m_stall); end
`endif
    end
    i_flush = 0;
  endtask

`ifdef FETCH_STALL_CNT_EN
  task automatic test_stall_cnt();
    bit found;
    do_reset();
    mem_lat = 4;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      checks++;
      if (o_stall_cnt !== m_stall) begin errors++; $display("FAIL stall_count: got %h expected %h", o_stall_cnt, m_stall); end
      if (o_id_valid) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stall_valid_timeout: got no valid expected valid"); end
    i_flush = 1; flush_target = 32'h0;
    for (int i = 0; i < 10; i++) cycle();
    @(negedge i_clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    m_stall = 32'hFFFF_FFFF;
    cycle();
    checks++;
    if (o_stall_cnt !== 32'h0 || m_stall !== 32'h0) begin
      errors++; $display("FAIL stall_wrap: got %h expected 0", o_stall_cnt);
    end
    i_flush = 0;
  endtask
`endif

  initial begin
    i_pc = 0; i_rst_n = 0; i_flush = 0; i_imem_ack = 0; i_imem_rdata = 0; i_id_ready = 0;
    flush_target = 0; fixed_word = 0; wait_cnt = 0; mem_lat = 1;
    auto_mem = 1; rand_lat = 0; fixed_en = 0;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_flush_drop();
    test_flush_ack();
    test_reset_in_wait();
    test_random();
`ifdef FETCH_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
